// File: rtl/route_arbiter.sv
// route_arbiter: per-port round-robin arbitration of x/y/local flits into 4 output slots with registered fail vector.
// Optional starvation priority is built in when ROUTE_ARB_STARVE_GUARD_EN is defined.
module route_arbiter #(
  parameter int DATA_W = 40,
  parameter int MAX_FAIL = 7,
  parameter int CNT_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_x,
  input  logic                req_y,
  input  logic                req_local,
  input  logic [1:0]          dst_x,
  input  logic [1:0]          dst_y,
  input  logic [1:0]          dst_local,
  input  logic [DATA_W-1:0]   din_x,
  input  logic [DATA_W-1:0]   din_y,
  input  logic [DATA_W-1:0]   din_local,
  output logic                gnt_x,
  output logic                gnt_y,
  output logic                gnt_local,
  output logic [2:0]          fail,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic [4*DATA_W-1:0] dout,
  output logic [15:0]         fail_cnt,
  output logic [2:0]          starve
);
  logic [2:0] req, gnt, starving;
  logic [1:0] rr [4];
  logic [2:0] win [4];
  logic [3:0] free;
  if (CNT_W < $clog2(MAX_FAIL + 1)) begin : g_cnt_w_check
    $error("CNT_W cannot hold MAX_FAIL");
  end
  // rotate so the pointed-at source is searched first, then rotate the one-hot result back
  function automatic logic [2:0] rr_pick(input logic [2:0] c, input logic [1:0] ptr);
    logic [5:0] d;
    logic [2:0] r;
    d = {c, c} >> ptr;
    r = d[0] ? 3'b001 : d[1] ? 3'b010 : d[2] ? 3'b100 : 3'b000;
    return ptr == 2'd1 ? {r[1:0], r[2]} : ptr == 2'd2 ? {r[0], r[2:1]} : r;
  endfunction
  assign req = {req_local, req_y, req_x};
  assign free = ~out_valid | out_ready;
  always_comb begin
    logic [2:0] cand, hot;
    for (int p = 0; p < 4; p++) begin
      cand = req & {dst_local == 2'(p), dst_y == 2'(p), dst_x == 2'(p)};
      hot = cand & starving;
      win[p] = !free[p] ? 3'b000 : |hot ? (hot & -hot) : rr_pick(cand, rr[p]);
    end
  end
  assign gnt = rst_n ? 3'b000 : win[0] | win[1] | win[2] | win[3];
  assign {gnt_local, gnt_y, gnt_x} = gnt;
  always_ff @(posedge clk) begin
    if (rst_n) begin
      out_valid <= '0;
      dout <= '0;
      fail <= '0;
      fail_cnt <= '0;
      for (int p = 0; p < 4; p++) rr[p] <= 2'd0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (|win[p]) begin
          out_valid[p] <= 1'b1;
          dout[p*DATA_W +: DATA_W] <= win[p][1] ? din_y : win[p][2] ? din_local : din_x;
          rr[p] <= win[p][0] ? 2'd1 : win[p][1] ? 2'd2 : 2'd0;
        end else if (free[p]) begin
          out_valid[p] <= 1'b0;
        end
      end
      fail <= req & ~gnt;
      if (|fail && ~&fail_cnt) fail_cnt <= fail_cnt + 16'd1;
    end
  end
`ifdef ROUTE_ARB_STARVE_GUARD_EN
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_FAIL);
  logic [CNT_W-1:0] cnt [3];
  always_ff @(posedge clk)
    for (int s = 0; s < 3; s++)
      cnt[s] <= rst_n || gnt[s] ? '0 : req[s] && cnt[s] < LIMIT ? cnt[s] + 1'b1 : cnt[s];
  always_comb begin
    starving = '0;
    for (int s = 0; s < 3; s++) starving[s] = cnt[s] >= LIMIT;
  end
`else
  assign starving = 3'b000;
`endif
  assign starve = starving;
endmodule

// File: tb/tb_route_arbiter.sv
// tb_route_arbiter: vector table, directed corner sequences and random traffic against a behavioural model.
module tb_route_arbiter;
  localparam int DW = 40;
  localparam int MF = 2;
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] req;
  logic [1:0] dst [3];
  logic [DW-1:0] din [3];
  logic [3:0] rdy;
  wire [2:0] gnt;
  logic [2:0] fail, starve, g_now;
  logic [3:0] out_valid;
  logic [4*DW-1:0] dout;
  logic [15:0] fail_cnt;
  int n_cmp = 0, n_bad = 0;
  int m_rr [4], m_win [4], m_sc [3], m_fc;
  bit m_vld [4];
  logic [DW-1:0] m_dat [4];
  logic [2:0] m_fail, m_gnt;
  typedef struct {
    logic [2:0] req;
    logic [1:0] dx, dy, dl;
    logic [3:0] rdy;
    logic [2:0] g;
    logic [3:0] ov;
    logic [2:0] f;
  } vec_t;
  vec_t tbl [8];

  route_arbiter #(.DATA_W(DW), .MAX_FAIL(MF), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_x(req[0]), .req_y(req[1]), .req_local(req[2]),
    .dst_x(dst[0]), .dst_y(dst[1]), .dst_local(dst[2]),
    .din_x(din[0]), .din_y(din[1]), .din_local(din[2]),
    .gnt_x(gnt[0]), .gnt_y(gnt[1]), .gnt_local(gnt[2]),
    .fail(fail), .out_valid(out_valid), .out_ready(rdy), .dout(dout),
    .fail_cnt(fail_cnt), .starve(starve)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [4*DW-1:0] act, input logic [4*DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic m_reset;
    for (int p = 0; p < 4; p++) begin
      m_rr[p] = 0;
      m_vld[p] = 0;
      m_dat[p] = '0;
    end
    for (int s = 0; s < 3; s++) m_sc[s] = 0;
    m_fail = '0;
    m_fc = 0;
  endtask

  task automatic m_eval;
    m_gnt = '0;
    for (int p = 0; p < 4; p++) begin
      m_win[p] = -1;
      if (!m_vld[p] || rdy[p]) begin
        for (int k = 0; k < 3; k++) begin
          int s = (m_rr[p] + k) % 3;
          if (m_win[p] < 0 && req[s] && dst[s] == p) m_win[p] = s;
        end
`ifdef ROUTE_ARB_STARVE_GUARD_EN
        for (int s = 2; s >= 0; s--)
          if (req[s] && dst[s] == p && m_sc[s] >= MF) m_win[p] = s;
`endif
        if (m_win[p] >= 0) m_gnt[m_win[p]] = 1'b1;
      end
    end
  endtask

  task automatic m_commit;
    if (m_fail != 0 && m_fc < 65535) m_fc++;
    m_fail = req & ~m_gnt;
    for (int s = 0; s < 3; s++)
      m_sc[s] = m_gnt[s] ? 0 : (req[s] && m_sc[s] < MF) ? m_sc[s] + 1 : m_sc[s];
    for (int p = 0; p < 4; p++) begin
      if (m_win[p] >= 0) begin
        m_vld[p] = 1;
        m_dat[p] = din[m_win[p]];
        m_rr[p] = (m_win[p] + 1) % 3;
      end else if (rdy[p]) begin
        m_vld[p] = 0;
      end
    end
  endtask

  task automatic check_regs;
    logic [4*DW-1:0] ed;
    logic [3:0] ev;
    logic [2:0] es;
    es = '0;
    for (int p = 0; p < 4; p++) begin
      ed[p*DW +: DW] = m_dat[p];
      ev[p] = m_vld[p];
    end
`ifdef ROUTE_ARB_STARVE_GUARD_EN
    for (int s = 0; s < 3; s++) es[s] = m_sc[s] >= MF;
`endif
    chk("m_out_valid", out_valid, ev);
    chk("m_dout", dout, ed);
    chk("m_fail", fail, m_fail);
    chk("m_fail_cnt", fail_cnt, 16'(m_fc));
    chk("m_starve", starve, es);
  endtask

  task automatic step;
    #1;
    m_eval;
    chk("m_gnt", gnt, m_gnt);
    g_now = gnt;
    @(posedge clk);
    m_commit;
    #1;
    check_regs;
  endtask

  task automatic reset_all;
    rst_n = 1'b1;
    req = 3'($urandom);
    rdy = 4'($urandom);
    for (int s = 0; s < 3; s++) begin
      dst[s] = 2'($urandom);
      din[s] = DW'({$urandom, $urandom});
    end
    #1;
    chk("rst_gnt", gnt, 3'b000);
    @(posedge clk);
    m_reset;
    #1;
    rst_n = 1'b0;
    req = '0;
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_dout", dout, '0);
    chk("rst_fail", fail, 3'b000);
    chk("rst_fail_cnt", fail_cnt, 16'd0);
    chk("rst_starve", starve, 3'b000);
  endtask

  initial begin
    tbl[0] = '{3'b001, 2'd1, 2'd0, 2'd0, 4'hF, 3'b001, 4'b0010, 3'b000};
    tbl[1] = '{3'b111, 2'd0, 2'd1, 2'd3, 4'hF, 3'b111, 4'b1011, 3'b000};
    tbl[2] = '{3'b111, 2'd2, 2'd2, 2'd2, 4'hF, 3'b001, 4'b0100, 3'b110};
    tbl[3] = '{3'b110, 2'd0, 2'd2, 2'd2, 4'hF, 3'b010, 4'b0100, 3'b100};
    tbl[4] = '{3'b111, 2'd3, 2'd0, 2'd3, 4'hF, 3'b011, 4'b1001, 3'b100};
    tbl[5] = '{3'b000, 2'd1, 2'd2, 2'd3, 4'hF, 3'b000, 4'b0000, 3'b000};
    tbl[6] = '{3'b100, 2'd1, 2'd1, 2'd0, 4'h0, 3'b100, 4'b0001, 3'b000};
    tbl[7] = '{3'b011, 2'd2, 2'd2, 2'd1, 4'h0, 3'b001, 4'b0100, 3'b010};
    for (int i = 0; i < 8; i++) begin
      reset_all;
      req = tbl[i].req;
      dst[0] = tbl[i].dx;
      dst[1] = tbl[i].dy;
      dst[2] = tbl[i].dl;
      rdy = tbl[i].rdy;
      for (int s = 0; s < 3; s++) din[s] = DW'(40'h10_0000_0000 * (s + 1) + i);
      step;
      chk("tbl_gnt", g_now, tbl[i].g);
      chk("tbl_out_valid", out_valid, tbl[i].ov);
      chk("tbl_fail", fail, tbl[i].f);
    end

    reset_all;
    req = 3'b001;
    dst[0] = 2'd1;
    din[0] = 40'h00_1234_5678;
    rdy = 4'hF;
    step;
    chk("single_gnt", g_now, 3'b001);
    chk("single_out_valid", out_valid, 4'b0010);
    chk("single_dout", dout[79:40], 40'h00_1234_5678);
    chk("single_fail", fail, 3'b000);

    begin
      logic [2:0] eg [3], ef [3];
      eg = '{3'b001, 3'b010, 3'b100};
      ef = '{3'b110, 3'b100, 3'b000};
      reset_all;
      req = 3'b111;
      for (int s = 0; s < 3; s++) dst[s] = 2'd2;
      rdy = 4'hF;
      for (int i = 0; i < 3; i++) begin
        step;
        chk("conflict_gnt", g_now, eg[i]);
        chk("conflict_fail", fail, ef[i]);
        req = req & ~g_now;
      end
      req = 3'b111;
      step;
      chk("conflict_rr_wrap", g_now, 3'b001);
    end

    reset_all;
    req = 3'b100;
    dst[2] = 2'd3;
    din[2] = 40'hAB_CDEF_0123;
    rdy = 4'h0;
    step;
    din[2] = 40'h55_5555_5555;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("bp_gnt", g_now, 3'b000);
      chk("bp_fail", fail, 3'b100);
      chk("bp_dout", dout[159:120], 40'hAB_CDEF_0123);
    end
    req = '0;
    step;
    chk("bp_fail_cnt", fail_cnt, 16'd4);

    reset_all;
    rdy = 4'h0;
    req = 3'b100;
    dst[2] = 2'd0;
    step;
    req = 3'b010;
    dst[1] = 2'd0;
    step;
    step;
`ifdef ROUTE_ARB_STARVE_GUARD_EN
    chk("starve_flag", starve, 3'b010);
`else
    chk("starve_flag", starve, 3'b000);
`endif
    rdy = 4'h1;
    req = 3'b011;
    dst[0] = 2'd0;
    step;
`ifdef ROUTE_ARB_STARVE_GUARD_EN
    chk("starve_winner", g_now, 3'b010);
`else
    chk("starve_winner", g_now, 3'b001);
`endif

    reset_all;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(99) == 0) reset_all;
      for (int s = 0; s < 3; s++)
        if (!req[s] && $urandom_range(1)) begin
          req[s] = 1'b1;
          dst[s] = 2'($urandom);
          din[s] = DW'({$urandom, $urandom});
        end
      rdy = 4'($urandom);
      step;
      req = req & ~g_now;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/route_arbiter.md
Name: route_arbiter

Overview:
- Front-end arbiter of the router output stage. It is the producer of the per-source fail vector that the conflict-recovery stage consumes.
- Sources x, y and local each present one 40-bit flit and its routed output port, a 2-bit code from the routing algorithm.
- For each of the 4 output ports, the block grants one source using round-robin, registers the winning flit into that port's output slot, and reports the losing sources on fail[2:0] one cycle later.

Parameters:
- DATA_W, 40, flit width.
- MAX_FAIL, 7, consecutive-fail threshold for the starvation guard.
- CNT_W, 3, width of the per-source starvation counters; must hold MAX_FAIL.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst_n  in  1  synchronous active-high reset. The port keeps this codebase name; it resets when 1.
- req_x, req_y, req_local  in  1 each  flit valid. Held until granted.
- dst_x, dst_y, dst_local  in  2 each  target output port code (0..3).
- din_x, din_y, din_local  in  DATA_W each  flit data. Stable while the matching req is held.
- gnt_x, gnt_y, gnt_local  out  1 each  combinational grant, same cycle as req. The source pops its flit on gnt.
- fail  out  3  registered. Bit0=x, bit1=y, bit2=local.
- out_valid  out  4  per-port slot valid.
- out_ready  in  4  per-port downstream accept.
- dout  out  4*DATA_W  port p data on bits [p*DATA_W +: DATA_W].
- fail_cnt  out  16  saturating count of cycles with fail != 0.
- starve  out  3  per-source starvation flag; tied 0 unless the optional feature is enabled.

Behaviour:
- Reset (rst_n=1 at a clock edge) clears: out_valid, dout, all rr pointers, fail, fail_cnt, starve counters.
  - Any flits held in slots are dropped.
  - gnt outputs are forced to 0 while rst_n=1.
- Slot p is free when out_valid[p]=0 or out_ready[p]=1. This gives same-cycle drain and refill, for zero-bubble streaming.
- Candidates for port p are the sources with req=1 and dst=p.
- If slot p is free and there is at least one candidate, exactly one winner is chosen:
  - Search starts at source index rr[p] (x=0, y=1, local=2) and proceeds in order x→y→local, wrapping.
  - The winner's gnt=1 in that cycle.
  - On the next edge: out_valid[p]<=1, dout slice p <= winner din, rr[p] <= (winner+1) mod 3.
- With no grant, rr[p] is unchanged.
  - If the slot is not free, it holds its data.
  - If the slot is free and out_ready[p]=1 drained it, out_valid[p]<=0.
- Valid/ready on the output side: data and valid stay stable while out_valid=1 and out_ready=0. A transfer happens on out_valid & out_ready.
- A source targets exactly one port per cycle, so it receives at most one grant. Requests to different ports are all granted in the same cycle.
- Latency:
  - req to gnt: 0 cycles.
  - req to out_valid: 1 cycle.
  - fail reflects the previous cycle: fail[s] <= req_s & ~gnt_s. This covers both a lost arbitration and a busy slot.
- fail_cnt increments when the registered fail is non-zero and saturates at 16'hFFFF.
- rr range is 0..2 only. A wrap from local goes to x.

Optional Feature:
Macro ROUTE_ARB_STARVE_GUARD_EN.
- When defined:
  - Each source has a CNT_W-bit counter.
  - The counter increments (saturating at MAX_FAIL) on every cycle the source requests and is not granted, and clears on grant.
  - starve[s] = (cnt_s >= MAX_FAIL).
  - A starving candidate beats round-robin for its port. If several starving candidates target the same port, the fixed order is x > y > local.
  - rr[p] still updates from the actual winner.
- When undefined: no counters, starve=3'b000, pure round-robin.

Test Plan:
1. Reset: drive random inputs, then rst_n=1 for 1 cycle. Required next cycle: out_valid=0, dout=0, fail=0, fail_cnt=0, all gnt=0.
2. Single request: req_x=1, dst_x=1, din_x=40'h00_1234_5678, out_ready=4'hF. Required: gnt_x=1 in the same cycle; next cycle out_valid=4'b0010, dout[79:40]=40'h00_1234_5678, fail=000.
3. Three-way conflict on port 2 from reset, all requests held and out_ready[2]=1:
   - Grant sequence over 3 cycles is x, y, local.
   - fail in the cycles after those grants is 110, then 100, then 000 (only local left and it wins).
   - rr[2] returns to 0.
4. Backpressure: slot 3 full, out_ready[3]=0, req_local=1 with dst_local=3 for 4 cycles.
   - Required: gnt_local=0, fail=100 on each following cycle, dout slice 3 unchanged, fail_cnt=4.
5. Parallel routing: x→0, y→1, local→3 in the same cycle, out_ready=F. Required: all three gnt=1, next cycle out_valid=4'b1011, fail=000.
6. Starvation guard, built with the macro defined and MAX_FAIL=2:
   - Stimulus: hold out_ready[0]=0 with slot 0 full and req_y to port 0 for 2 cycles (starve[1]=1). Then set out_ready[0]=1 with rr[0]=0 and req_x also targeting port 0.
   - Required: gnt_y=1.
   - Same stimulus with the macro undefined: gnt_x=1.
